// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// Memory-side target for the CPU's active-low SRAM strobes. Holds a
// word-addressed store with independent upper/lower byte lanes and inserts
// fixed read/write wait states so multi-cycle CPU access states line up
// cycle-exactly with the memory.
//
// Ports
//   Clk         clock, all state updates on the rising edge
//   Reset_n     synchronous active-low reset (store contents are kept)
//   Mem_CE      chip enable, active low
//   Mem_UB      upper byte [15:8] enable, active low
//   Mem_LB      lower byte [7:0] enable, active low
//   Mem_OE      output (read) enable, active low
//   Mem_WE      write enable, active low (wins over OE)
//   Addr        word address; bits above DEPTH_LOG2 alias onto the store
//   Data_in     write data
//   Data_out    last completed read word, held between reads
//   Data_valid  Data_out belongs to the read currently on the bus
//   Err         one-cycle pulse after an edge that saw CE, OE and WE all low
//   Rd_count    completed reads (saturating)
//   Wr_count    committed writes (saturating)
//
// Build option
//   SRAM_STATS_EN  when defined, Rd_count/Wr_count are live counters;
//                  otherwise no counter logic and both outputs read 0.
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LAT   = 2,
    parameter int WRITE_LAT  = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Mem_CE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_valid,
    output logic              Err,
    output logic [15:0]       Rd_count,
    output logic [15:0]       Wr_count
);

    localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int DEPTH   = 1 << DEPTH_LOG2;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WRITE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_WAIT,
        WR_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]       dout_q;
    logic                    err_q;
    logic                    rd_req, wr_req;
    logic                    load, commit;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [DATA_W-1:0]       mem [DEPTH];

    // A disabled lane reads back as zero.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] w,
                                                    input logic ub_n,
                                                    input logic lb_n);
        return {(ub_n ? 8'h00 : w[15:8]), (lb_n ? 8'h00 : w[7:0])};
    endfunction

    assign rd_req  = !Mem_CE && !Mem_OE && Mem_WE;
    assign wr_req  = !Mem_CE && !Mem_WE;
    assign cnt_inc = cnt_q + CNT_ONE;

    // Next-state logic. A new access always starts with cnt=1; when the
    // latency is 1 that first edge already completes it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        wr_idx  = addr_q[DEPTH_LOG2-1:0];

        if (Mem_CE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, RD_WAIT, RD_DATA: begin
                    if (wr_req) begin
                        addr_d = Addr;
                        cnt_d  = CNT_ONE;
                        wr_idx = Addr[DEPTH_LOG2-1:0];
                        if (WR_LAT_C == CNT_ONE) begin
                            commit  = 1'b1;
                            state_d = WR_HOLD;
                        end else begin
                            state_d = WR_WAIT;
                        end
                    end else if (rd_req) begin
                        if (state_q == IDLE || Addr != addr_q) begin
                            // New read or address moved: restart the wait.
                            addr_d = Addr;
                            cnt_d  = CNT_ONE;
                            if (RD_LAT_C == CNT_ONE) begin
                                load    = 1'b1;
                                state_d = RD_DATA;
                            end else begin
                                state_d = RD_WAIT;
                            end
                        end else if (state_q == RD_WAIT) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == RD_LAT_C) begin
                                load    = 1'b1;
                                state_d = RD_DATA;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                WR_WAIT: begin
                    if (wr_req) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == WR_LAT_C) begin
                            commit  = 1'b1;
                            state_d = WR_HOLD;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                WR_HOLD: begin
                    // One commit per WE-low period; wait for WE to rise.
                    if (!wr_req) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Reset aborts any access, including a write due this edge.
        if (!Reset_n) begin
            commit = 1'b0;
            load   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= !Mem_CE && !Mem_OE && !Mem_WE;
            if (load) begin
                dout_q <= lane_mask(mem[Addr[DEPTH_LOG2-1:0]], Mem_UB, Mem_LB);
            end
        end
    end

    always_ff @(posedge Clk) begin
        addr_q <= addr_d;
    end

    // Store is never cleared; lanes follow UB/LB at the commit edge.
    always_ff @(posedge Clk) begin
        if (commit) begin
            if (!Mem_UB) mem[wr_idx][15:8] <= Data_in[15:8];
            if (!Mem_LB) mem[wr_idx][7:0]  <= Data_in[7:0];
        end
    end

    always_comb begin
        Data_out   = dout_q;
        Data_valid = (state_q == RD_DATA);
        Err        = err_q;
    end

`ifdef SRAM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (load)   rd_cnt_q <= sat_inc(rd_cnt_q);
            if (commit) wr_cnt_q <= sat_inc(wr_cnt_q);
        end
    end

    assign Rd_count = rd_cnt_q;
    assign Wr_count = wr_cnt_q;
`else
    assign Rd_count = 16'h0000;
    assign Wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//
// Drives two responders from one strobe bus: the default build and a
// WRITE_LAT=3 build. Expected read data comes from a word array updated with
// the byte-lane rules; expected counters come from operation tallies.
// ---------------------------------------------------------------------------
module tb_sram_responder;

    logic        Clk     = 1'b0;
    logic        Reset_n = 1'b0;
    logic        CE = 1'b1, UB = 1'b0, LB = 1'b0, OE = 1'b1, WE = 1'b1;
    logic [15:0] Addr = 16'h0, Din = 16'h0;
    logic [15:0] Dout, RdC, WrC, Dout3, RdC3, WrC3;
    logic        Dv, Err, Dv3, Err3;

    int total = 0;
    int bad   = 0;
    int m_rd  = 0;
    int m_wr  = 0;
    logic [15:0] m_mem [1024];

    sram_responder dut (
        .Clk(Clk), .Reset_n(Reset_n), .Mem_CE(CE), .Mem_UB(UB), .Mem_LB(LB),
        .Mem_OE(OE), .Mem_WE(WE), .Addr(Addr), .Data_in(Din),
        .Data_out(Dout), .Data_valid(Dv), .Err(Err),
        .Rd_count(RdC), .Wr_count(WrC)
    );

    sram_responder #(.WRITE_LAT(3)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Mem_CE(CE), .Mem_UB(UB), .Mem_LB(LB),
        .Mem_OE(OE), .Mem_WE(WE), .Addr(Addr), .Data_in(Din),
        .Data_out(Dout3), .Data_valid(Dv3), .Err(Err3),
        .Rd_count(RdC3), .Wr_count(WrC3)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] lanes(input logic [15:0] w, input logic ub, input logic lb);
        return {(ub ? 8'h00 : w[15:8]), (lb ? 8'h00 : w[7:0])};
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef SRAM_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [15:0] d,
                               input logic ub, input logic lb);
        if (!ub) m_mem[a[9:0]][15:8] = d[15:8];
        if (!lb) m_mem[a[9:0]][7:0]  = d[7:0];
        m_wr++;
    endtask

    // Single-cycle WE pulse followed by one idle cycle.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        CE = 1'b0; OE = 1'b1; WE = 1'b0; Addr = a; Din = d; UB = ub; LB = lb;
        tick();
        bus_idle();
        tick();
        model_write(a, d, ub, lb);
    endtask

    // WE held low for n cycles; the default build commits on the first.
    task automatic long_write(input logic [15:0] a, input logic [15:0] d, input int n);
        CE = 1'b0; OE = 1'b1; WE = 1'b0; Addr = a; Din = d; UB = 1'b0; LB = 1'b0;
        repeat (n) tick();
        bus_idle();
        tick();
        model_write(a, d, 1'b0, 1'b0);
    endtask

    // OE low for two edges from idle; returns what both responders showed.
    task automatic do_read(input logic [15:0] a, input logic ub, input logic lb,
                           output logic [15:0] d, output logic v1, output logic v2,
                           output logic [15:0] d3, output logic v3);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; Addr = a; UB = ub; LB = lb;
        tick();
        v1 = Dv;
        tick();
        v2 = Dv; d = Dout; d3 = Dout3; v3 = Dv3;
        bus_idle();
        tick();
        m_rd++;
    endtask

    task automatic test_reset();
        bus_idle();
        Reset_n = 1'b0;
        tick();
        tick();
        total++; if (Dout !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h want=0000", Dout); end
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", Dv); end
        total++; if (Err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", Err); end
        total++; if (RdC !== 16'h0000) begin bad++; $display("FAIL reset_rdcnt got=%h want=0000", RdC); end
        total++; if (WrC !== 16'h0000) begin bad++; $display("FAIL reset_wrcnt got=%h want=0000", WrC); end
        total++; if ({Dv3, RdC3, WrC3} !== 33'h0) begin bad++; $display("FAIL reset_dut3 got=%b/%h/%h want=0/0000/0000", Dv3, RdC3, WrC3); end
        Reset_n = 1'b1;
        m_rd = 0; m_wr = 0;
        tick();
        total++; if ({Dv, Err} !== 2'b00) begin bad++; $display("FAIL reset_release got=%b want=00", {Dv, Err}); end
    endtask

    task automatic test_write_read();
        logic [15:0] exp;
        do_write(16'h0005, 16'h1234, 1'b0, 1'b0);
        exp = lanes(m_mem[5], 1'b0, 1'b0);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; Addr = 16'h0005; UB = 1'b0; LB = 1'b0;
        tick();
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL wr_rd_early_valid got=%b want=0", Dv); end
        tick();
        total++; if (Dv !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b want=1", Dv); end
        total++; if (Dout !== 16'h1234 || Dout !== exp) begin bad++; $display("FAIL wr_rd_data got=%h want=1234", Dout); end
        tick();
        total++; if (Dv !== 1'b1) begin bad++; $display("FAIL wr_rd_hold_valid got=%b want=1", Dv); end
        OE = 1'b1;
        tick();
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL wr_rd_oe_drop got=%b want=0", Dv); end
        total++; if (Dout !== 16'h1234) begin bad++; $display("FAIL wr_rd_dout_held got=%h want=1234", Dout); end
        bus_idle();
        tick();
        m_rd++;
    endtask

    task automatic test_lanes();
        logic [15:0] d, d3;
        logic v1, v2, v3;
        do_write(16'h0007, 16'h1234, 1'b0, 1'b0);
        do_write(16'h0007, 16'hABCD, 1'b1, 1'b0);
        do_read(16'h0007, 1'b0, 1'b0, d, v1, v2, d3, v3);
        total++; if ({v1, v2, d} !== {2'b01, 16'h12CD}) begin bad++; $display("FAIL lane_write got=%b%b/%h want=01/12CD", v1, v2, d); end
        do_read(16'h0007, 1'b0, 1'b1, d, v1, v2, d3, v3);
        total++; if ({v1, v2, d} !== {2'b01, 16'h1200}) begin bad++; $display("FAIL lane_read got=%b%b/%h want=01/1200", v1, v2, d); end
    endtask

    task automatic test_addr_change();
        logic [15:0] exp;
        do_write(16'h0006, 16'h6666, 1'b0, 1'b0);
        exp = m_mem[6];
        CE = 1'b0; OE = 1'b0; WE = 1'b1; Addr = 16'h0005; UB = 1'b0; LB = 1'b0;
        tick();
        Addr = 16'h0006;
        tick();
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL addr_chg_restart got=%b want=0", Dv); end
        tick();
        total++; if ({Dv, Dout} !== {1'b1, exp}) begin bad++; $display("FAIL addr_chg_read got=%b/%h want=1/%h", Dv, Dout, exp); end
        // Turn the read into a write at the same address.
        WE = 1'b0; Din = 16'h7777;
        tick();
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL write_state_valid got=%b want=0", Dv); end
        model_write(16'h0006, 16'h7777, 1'b0, 1'b0);
        m_rd++;
        bus_idle();
        tick();
        total++; if (Dout !== exp) begin bad++; $display("FAIL dout_hold got=%h want=%h", Dout, exp); end
    endtask

    task automatic test_err();
        logic [15:0] d, d3;
        logic v1, v2, v3;
        CE = 1'b0; OE = 1'b0; WE = 1'b0; Addr = 16'h0010; Din = 16'h5555; UB = 1'b0; LB = 1'b0;
        tick();
        total++; if ({Err, Err3} !== 2'b11) begin bad++; $display("FAIL err_pulse got=%b%b want=11", Err, Err3); end
        bus_idle();
        tick();
        total++; if (Err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", Err); end
        model_write(16'h0010, 16'h5555, 1'b0, 1'b0);
        do_read(16'h0010, 1'b0, 1'b0, d, v1, v2, d3, v3);
        total++; if ({v2, d} !== {1'b1, 16'h5555}) begin bad++; $display("FAIL err_write_data got=%b/%h want=1/5555", v2, d); end
    endtask

    task automatic test_random();
        logic [15:0] a, d, d3, exp;
        logic v1, v2, v3, ub, lb;
        for (int i = 0; i < 16; i++) begin
            do_write({6'($urandom), 10'(32 + i)}, 16'($urandom), 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            a  = {6'($urandom), 10'(32 + $urandom_range(0, 15))};
            ub = 1'($urandom);
            lb = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, 16'($urandom), ub, lb);
            end else begin
                exp = lanes(m_mem[a[9:0]], ub, lb);
                do_read(a, ub, lb, d, v1, v2, d3, v3);
                total++;
                if ({v1, v2, d} !== {2'b01, exp}) begin
                    bad++;
                    $display("FAIL rand_read a=%h ub=%b lb=%b got=%b%b/%h want=01/%h", a, ub, lb, v1, v2, d, exp);
                end
            end
        end
        total++; if (RdC !== exp_cnt(m_rd)) begin bad++; $display("FAIL rand_rdcnt got=%h want=%h", RdC, exp_cnt(m_rd)); end
        total++; if (WrC !== exp_cnt(m_wr)) begin bad++; $display("FAIL rand_wrcnt got=%h want=%h", WrC, exp_cnt(m_wr)); end
    endtask

    task automatic test_write_lat3();
        logic [15:0] d, d3;
        logic v1, v2, v3;
        CE = 1'b0; OE = 1'b1; WE = 1'b0; Addr = 16'h0040; Din = 16'h0F0F; UB = 1'b0; LB = 1'b0;
        tick();
        total++; if (Dv3 !== 1'b0) begin bad++; $display("FAIL lat3_wait_valid got=%b want=0", Dv3); end
        tick();
        tick();
        bus_idle();
        tick();
        model_write(16'h0040, 16'h0F0F, 1'b0, 1'b0);
        // Too short for the slow build: only the default build commits.
        long_write(16'h0040, 16'hF0F0, 2);
        do_read(16'h0040, 1'b0, 1'b0, d, v1, v2, d3, v3);
        total++; if (d3 !== 16'h0F0F || v3 !== 1'b1) begin bad++; $display("FAIL lat3_short_we got=%b/%h want=1/0F0F", v3, d3); end
        total++; if (d !== 16'hF0F0) begin bad++; $display("FAIL lat1_short_we got=%h want=F0F0", d); end
        // Reset on the edge that would have committed in the slow build.
        long_write(16'h0041, 16'h1111, 3);
        CE = 1'b0; OE = 1'b1; WE = 1'b0; Addr = 16'h0041; Din = 16'h2222;
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        model_write(16'h0041, 16'h2222, 1'b0, 1'b0);
        m_rd = 0; m_wr = 0;
        Reset_n = 1'b1;
        bus_idle();
        tick();
        do_read(16'h0041, 1'b0, 1'b0, d, v1, v2, d3, v3);
        total++; if (d3 !== 16'h1111) begin bad++; $display("FAIL lat3_reset_abort got=%h want=1111", d3); end
        total++; if (d !== 16'h2222) begin bad++; $display("FAIL lat1_before_reset got=%h want=2222", d); end
    endtask

    task automatic test_reset_mid_read();
        do_write(16'h0050, 16'hBEEF, 1'b0, 1'b0);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; Addr = 16'h0050; UB = 1'b0; LB = 1'b0;
        tick();
        Reset_n = 1'b0;
        tick();
        m_rd = 0; m_wr = 0;
        total++; if ({Dv, Dout} !== {1'b0, 16'h0000}) begin bad++; $display("FAIL mid_read_reset got=%b/%h want=0/0000", Dv, Dout); end
        Reset_n = 1'b1;
        tick();
        total++; if (Dv !== 1'b0) begin bad++; $display("FAIL post_reset_wait got=%b want=0", Dv); end
        tick();
        total++; if ({Dv, Dout} !== {1'b1, m_mem[10'h050]}) begin bad++; $display("FAIL post_reset_read got=%b/%h want=1/BEEF", Dv, Dout); end
        m_rd++;
        bus_idle();
        tick();
    endtask

    task automatic test_stats();
        logic [15:0] d, d3;
        logic v1, v2, v3;
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        m_rd = 0; m_wr = 0;
        do_write(16'h0060, 16'hC0DE, 1'b0, 1'b0);
        do_write(16'h0061, 16'h0BAD, 1'b0, 1'b0);
        do_read(16'h0060, 1'b0, 1'b0, d, v1, v2, d3, v3);
        do_read(16'h0061, 1'b0, 1'b0, d, v1, v2, d3, v3);
        do_read(16'h0005, 1'b0, 1'b0, d, v1, v2, d3, v3);
        total++; if (d !== 16'h1234) begin bad++; $display("FAIL mem_kept_over_reset got=%h want=1234", d); end
        total++; if (RdC !== exp_cnt(3)) begin bad++; $display("FAIL stats_rd got=%h want=%h", RdC, exp_cnt(3)); end
        total++; if (WrC !== exp_cnt(2)) begin bad++; $display("FAIL stats_wr got=%h want=%h", WrC, exp_cnt(2)); end
        total++; if ({RdC3, WrC3} !== {exp_cnt(3), 16'h0000}) begin bad++; $display("FAIL stats_dut3 got=%h/%h want=%h/0000", RdC3, WrC3, exp_cnt(3)); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_lanes();
        test_addr_change();
        test_err();
        test_random();
        test_write_lat3();
        test_reset_mid_read();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
